// File: rtl/pipe_stage_skid.sv
// Elastic backend pipeline stage: a head register that drives the outputs and
// one skid register behind it. Upstream ready comes straight from a flop, so
// out_ready never reaches in_ready through logic in the same cycle.
// A redirect flush kills only entries younger than the redirecting rob id. With
// FLUSH_BY_AGE=0 it kills every entry instead.
//
//  state    | meaning
//  ---------+---------------------------------------------
//  ST_EMPTY | head and skid both invalid, occupancy 0
//  ST_ONE   | head valid, skid invalid, occupancy 1
//  ST_FULL  | head and skid both valid, occupancy 2
module pipe_stage_skid #(
  parameter int DATA_W       = 256,
  parameter int ROBID_W      = 7,
  parameter bit FLUSH_BY_AGE = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [ROBID_W-1:0] in_robid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [ROBID_W-1:0] out_robid,
  input  logic               flush_valid,
  input  logic [ROBID_W-1:0] flush_robid,
  output logic [1:0]         occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_nxt;
  logic               in_ready_q;

  logic [DATA_W-1:0]  head_data_q;
  logic [ROBID_W-1:0] head_robid_q;
  logic [DATA_W-1:0]  skid_data_q;
  logic [ROBID_W-1:0] skid_robid_q;

  logic               head_v;
  logic               skid_v;
  logic               push;
  logic               pop;
  logic               head_kill;
  logic               skid_kill;
  logic               head_stays;
  logic               skid_stays;
  logic               head_load_in;
  logic               head_load_skid;
  logic               skid_load_in;

  // The wrap bit flips each time the rob index wraps around. When the wrap bits
  // differ, the index order is reversed. An equal id is never younger, so the
  // redirecting instruction survives its own flush.
  function automatic logic younger(input logic [ROBID_W-1:0] a,
                                   input logic [ROBID_W-1:0] b);
    return (a[ROBID_W-1] != b[ROBID_W-1]) ^ (a[ROBID_W-2:0] > b[ROBID_W-2:0]);
  endfunction

  // Decide the kill, transfer and next occupancy. A flush blocks the push but
  // still lets a surviving head pop.
  always_comb begin
    state_nxt      = ST_EMPTY;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load_in   = 1'b0;

    head_v = (state_q != ST_EMPTY);
    skid_v = (state_q == ST_FULL);
    pop    = head_v & out_ready;
    // The input is on the wrong path during a flush, so it is never written.
    push   = in_valid & in_ready_q & ~flush_valid;

    if (FLUSH_BY_AGE) begin
      head_kill = flush_valid & younger(head_robid_q, flush_robid);
      skid_kill = flush_valid & younger(skid_robid_q, flush_robid);
    end else begin
      head_kill = flush_valid;
      skid_kill = flush_valid;
    end

    head_stays = head_v & ~pop & ~head_kill;
    skid_stays = skid_v & ~skid_kill;

    // When in_ready is high, the skid is empty. A push therefore never competes
    // with a skid entry for the free slot.
    if (head_stays) begin
      if (skid_stays) begin
        state_nxt = ST_FULL;
      end else if (push) begin
        skid_load_in = 1'b1;
        state_nxt    = ST_FULL;
      end else begin
        state_nxt = ST_ONE;
      end
    end else if (skid_stays) begin
      head_load_skid = 1'b1;
      state_nxt      = ST_ONE;
    end else if (push) begin
      head_load_in = 1'b1;
      state_nxt    = ST_ONE;
    end else begin
      state_nxt = ST_EMPTY;
    end
  end

  // Occupancy state and registered upstream ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end

  // The head payload changes only on a load. This holds the outputs steady
  // while downstream stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_data_q  <= '0;
      head_robid_q <= '0;
    end else if (head_load_skid) begin
      head_data_q  <= skid_data_q;
      head_robid_q <= skid_robid_q;
    end else if (head_load_in) begin
      head_data_q  <= in_data;
      head_robid_q <= in_robid;
    end
  end

  // The skid captures the input only when the head is occupied and stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      skid_data_q  <= '0;
      skid_robid_q <= '0;
    end else if (skid_load_in) begin
      skid_data_q  <= in_data;
      skid_robid_q <= in_robid;
    end
  end

  // Outputs are direct views of the registers.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q != ST_EMPTY);
    out_data  = head_data_q;
    out_robid = head_robid_q;
    occupancy = state_q;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid.
// A queue-based scoreboard models the live entries in age order.
module tb_pipe_stage_skid;

  localparam int DW = 256;
  localparam int RW = 7;

  typedef struct packed {
    logic [RW-1:0] robid;
    logic [DW-1:0] data;
  } ent_t;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_robid;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_robid;
  logic          flush_valid;
  logic [RW-1:0] flush_robid;
  logic [1:0]    occupancy;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipe_stage_skid #(.DATA_W(DW), .ROBID_W(RW), .FLUSH_BY_AGE(1'b1)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_robid    (in_robid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_robid   (out_robid),
    .flush_valid (flush_valid),
    .flush_robid (flush_robid),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk_data(input logic [RW-1:0] id);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++)
      d[i*32 +: 32] = 32'hC0DE_0000 + 32'(i * 256) + {25'd0, id};
    return d;
  endfunction

  // Age model: with the same wrap bit, the larger index is younger. With
  // different wrap bits, an index less than or equal is younger.
  function automatic logic younger_m(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW-2:0] ai;
    logic [RW-2:0] bi;
    ai = a[RW-2:0];
    bi = b[RW-2:0];
    if (a[RW-1] == b[RW-1]) return ai > bi;
    else                    return ai <= bi;
  endfunction

  // Run one clock cycle. Drive at the negedge, model the edge, then check the
  // state at the following negedge.
  task automatic cycle(input logic iv, input logic [RW-1:0] id, input logic orr,
                       input logic fv, input logic [RW-1:0] fid);
    ent_t e;
    int   sz0;
    sz0         = sb.size();
    in_valid    = iv;
    in_robid    = id;
    in_data     = mk_data(id);
    out_ready   = orr;
    flush_valid = fv;
    flush_robid = fid;
    #1;
    if (orr && sz0 != 0) begin
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_robid !== e.robid || out_data !== e.data) begin
        errors++;
        $display("FAIL pop_head got v=%0b robid=%0h data=%0h required robid=%0h data=%0h",
                 out_valid, out_robid, out_data[31:0], e.robid, e.data[31:0]);
      end
    end
    if (fv) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (younger_m(sb[i].robid, fid)) sb.delete(i);
    end
    if (iv && sz0 != 2 && !fv) begin
      e.robid = id;
      e.data  = mk_data(id);
      sb.push_back(e);
    end
    @(negedge clock);
    checks++;
    if (occupancy !== 2'(sb.size()) || in_ready !== (sb.size() != 2) ||
        out_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL state got occ=%0d in_ready=%0b out_valid=%0b required occ=%0d",
               occupancy, in_ready, out_valid, sb.size());
    end
    if (sb.size() != 0) begin
      checks++;
      if (out_robid !== sb[0].robid || out_data !== sb[0].data) begin
        errors++;
        $display("FAIL head got robid=%0h data=%0h required robid=%0h data=%0h",
                 out_robid, out_data[31:0], sb[0].robid, sb[0].data[31:0]);
      end
    end
  endtask

  task automatic idle(input logic orr);
    cycle(1'b0, '0, orr, 1'b0, '0);
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_robid    = '0;
    in_data     = '0;
    out_ready   = 1'b0;
    flush_valid = 1'b0;
    flush_robid = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_robid !== '0 ||
        occupancy !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset got v=%0b data=%0h robid=%0h occ=%0d rdy=%0b required 0 0 0 0 1",
               out_valid, out_data[31:0], out_robid, occupancy, in_ready);
    end
  endtask

  task automatic test_streaming;
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, RW'(i), 1'b1, 1'b0, '0);
      checks++;
      if (out_robid !== RW'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream got robid=%0h occ=%0d rdy=%0b required robid=%0h occ=1 rdy=1",
                 out_robid, occupancy, in_ready, i);
      end
    end
    idle(1'b1);
  endtask

  task automatic test_backpressure;
    cycle(1'b1, 7'd4, 1'b0, 1'b0, '0);
    cycle(1'b1, 7'd5, 1'b0, 1'b0, '0);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_robid !== 7'd4) begin
      errors++;
      $display("FAIL backpressure got occ=%0d rdy=%0b robid=%0h required occ=2 rdy=0 robid=4",
               occupancy, in_ready, out_robid);
    end
    cycle(1'b1, 7'd6, 1'b0, 1'b0, '0);
    idle(1'b1);
    checks++;
    if (out_robid !== 7'd5 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_drain got robid=%0h occ=%0d required robid=5 occ=1", out_robid, occupancy);
    end
    idle(1'b1);
  endtask

  task automatic test_age_flush;
    cycle(1'b1, 7'd10, 1'b0, 1'b0, '0);
    cycle(1'b1, 7'd12, 1'b0, 1'b0, '0);
    cycle(1'b1, 7'd13, 1'b0, 1'b1, 7'd11);
    checks++;
    if (out_valid !== 1'b1 || out_robid !== 7'd10 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL age_flush got v=%0b robid=%0h occ=%0d rdy=%0b required 1 10 1 1",
               out_valid, out_robid, occupancy, in_ready);
    end
    idle(1'b1);
    cycle(1'b1, 7'd14, 1'b0, 1'b1, 7'd20);
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drops_input got occ=%0d v=%0b required occ=0 v=0", occupancy, out_valid);
    end
  endtask

  task automatic test_wrap_flush;
    cycle(1'b1, 7'h7E, 1'b0, 1'b0, '0);
    cycle(1'b1, 7'h01, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 7'h7E);
    checks++;
    if (occupancy !== 2'd1 || out_robid !== 7'h7E) begin
      errors++;
      $display("FAIL wrap_keep_head got occ=%0d robid=%0h required occ=1 robid=7e",
               occupancy, out_robid);
    end
    cycle(1'b1, 7'h01, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 7'h7D);
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_kill_both got occ=%0d v=%0b rdy=%0b required 0 0 1",
               occupancy, out_valid, in_ready);
    end
  endtask

  task automatic test_flush_promote;
    cycle(1'b1, 7'd20, 1'b0, 1'b0, '0);
    cycle(1'b1, 7'd21, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 1'b1, 7'd21);
    checks++;
    if (out_valid !== 1'b1 || out_robid !== 7'd21 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL promote got v=%0b robid=%0h occ=%0d required 1 21 1",
               out_valid, out_robid, occupancy);
    end
    idle(1'b1);
  endtask

  task automatic test_reset_mid;
    cycle(1'b1, 7'd30, 1'b0, 1'b0, '0);
    cycle(1'b1, 7'd31, 1'b0, 1'b0, '0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_robid !== '0) begin
      errors++;
      $display("FAIL reset_mid got occ=%0d v=%0b rdy=%0b robid=%0h required 0 0 1 0",
               occupancy, out_valid, in_ready, out_robid);
    end
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    idle(1'b1);
  endtask

  task automatic test_back_to_back;
    logic [RW-1:0] nid;
    logic          fv;
    nid = 7'd40;
    for (int n = 0; n < 400; n++) begin
      fv = ($urandom_range(0, 7) == 0);
      cycle(1'($urandom_range(0, 3) != 0), nid, 1'($urandom_range(0, 2) != 0),
            fv, nid - RW'($urandom_range(1, 4)));
      nid = nid + 7'd1;
    end
    while (sb.size() != 0) idle(1'b1);
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_backpressure;
    test_age_flush;
    test_wrap_flush;
    test_flush_promote;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
